sample_capture: RTL and testbench

// Triggered capture buffer sitting directly downstream of sinegen; records its dout sample stream.

---
 rtl/sample_capture.sv | 178 +++++++++++++++++
 tb/tb_sample_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_capture.sv
// ============================================================================
// Module   : sample_capture
// Brief    : Triggered capture buffer for a sample stream. Keeps pre-trigger
//            history in a circular RAM, fills post-trigger samples, then
//            streams the record oldest-first over a valid/ready port.
//            Optional macro CAPTURE_AUTO_TRIG_EN adds a rising-level trigger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_capture #(
    parameter int D_WIDTH    = 8,
    parameter int A_WIDTH    = 8,
    parameter int TRIG_LEVEL = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din,
    input  logic               arm,
    input  logic               trig,
    input  logic [A_WIDTH-1:0] pretrig,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               rd_last,
    output logic               busy,
    output logic               done
);

    localparam int                 c_depth      = 1 << A_WIDTH;
    localparam logic [A_WIDTH:0]   c_fill_max   = {1'b1, {A_WIDTH{1'b0}}};
    localparam logic [A_WIDTH:0]   c_one_f      = (A_WIDTH+1)'(1);
    localparam logic [A_WIDTH-1:0] c_one_a      = A_WIDTH'(1);
    localparam logic [A_WIDTH-1:0] c_pt_max     = {A_WIDTH{1'b1}};
    localparam logic [D_WIDTH-1:0] c_trig_level = TRIG_LEVEL[D_WIDTH-1:0];

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_armed = 2'd1;
    localparam logic [1:0] c_st_post  = 2'd2;
    localparam logic [1:0] c_st_read  = 2'd3;

    logic [1:0]         r_state;
    logic [A_WIDTH-1:0] r_wptr;
    logic [A_WIDTH:0]   r_fill;
    logic [A_WIDTH-1:0] r_pt;
    logic [A_WIDTH-1:0] r_post;
    logic [A_WIDTH-1:0] r_tptr;
    logic [A_WIDTH-1:0] r_raddr;
    logic [A_WIDTH:0]   r_left;
    logic               r_rd_init;
    logic               r_rd_valid;
    logic [D_WIDTH-1:0] r_rd_data;
    logic               r_rd_last;
    logic               r_done;
    logic [D_WIDTH-1:0] r_mem [c_depth];

    logic w_trig;
    logic w_we;
    logic w_load;

`ifdef CAPTURE_AUTO_TRIG_EN
    logic [D_WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
        end else if (en) begin
            r_prev <= din;
        end
    end

    assign w_trig = trig | ((r_prev < c_trig_level) && (din >= c_trig_level));
`else
    logic w_unused_trig_level;
    assign w_unused_trig_level = ^c_trig_level;
    assign w_trig              = trig;
`endif

    assign w_we   = en && !rst && ((r_state == c_st_armed) || (r_state == c_st_post));
    // Refill the output register whenever it is empty or being consumed this cycle.
    assign w_load = (r_left != '0) && (!r_rd_valid || rd_ready);

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_wptr     <= '0;
            r_fill     <= '0;
            r_pt       <= '0;
            r_post     <= '0;
            r_tptr     <= '0;
            r_raddr    <= '0;
            r_left     <= '0;
            r_rd_init  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (arm) begin
                        r_pt    <= pretrig;
                        r_fill  <= '0;
                        r_state <= c_st_armed;
                    end
                end
                c_st_armed: begin
                    if (en) begin
                        r_wptr <= r_wptr + c_one_a;
                        if (r_fill != c_fill_max) begin
                            r_fill <= r_fill + c_one_f;
                        end
                        // Fill is compared before this cycle's write is counted.
                        if (w_trig && (r_fill >= {1'b0, r_pt})) begin
                            r_tptr <= r_wptr;
                            r_post <= ~r_pt;
                            if (r_pt == c_pt_max) begin
                                r_state   <= c_st_read;
                                r_done    <= 1'b1;
                                r_rd_init <= 1'b1;
                            end else begin
                                r_state <= c_st_post;
                            end
                        end
                    end
                end
                c_st_post: begin
                    if (en) begin
                        r_wptr <= r_wptr + c_one_a;
                        r_post <= r_post - c_one_a;
                        if (r_post == c_one_a) begin
                            r_state   <= c_st_read;
                            r_done    <= 1'b1;
                            r_rd_init <= 1'b1;
                        end
                    end
                end
                c_st_read: begin
                    if (r_rd_init) begin
                        r_rd_init <= 1'b0;
                        r_raddr   <= r_tptr - r_pt;
                        r_left    <= c_fill_max;
                    end else if (w_load) begin
                        r_rd_data  <= r_mem[r_raddr];
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= (r_left == c_one_f);
                        r_raddr    <= r_raddr + c_one_a;
                        r_left     <= r_left - c_one_f;
                    end else if (r_rd_valid && rd_ready) begin
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                        if (r_rd_last) begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_last  = r_rd_last;
    assign done     = r_done;
    assign busy     = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_sample_capture.sv
// ============================================================================
// Module   : tb_sample_capture
// Brief    : Directed, table-driven bench for sample_capture (DEPTH = 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_capture;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic       arm;
    logic       trig;
    logic [3:0] pretrig;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic       done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int pretrig;
        int trig_val;
        int early_val;
        int period;
        bit rand_rdy;
        bit arm_in_read;
        int first;
        int done_val;
    } vec_t;

    vec_t vecs[7];

    sample_capture #(
        .D_WIDTH   (8),
        .A_WIDTH   (4),
        .TRIG_LEVEL(128)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din),
        .arm     (arm),
        .trig    (trig),
        .pretrig (pretrig),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rd_last (rd_last),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_capture(input vec_t v);
        int  d;
        int  last_wr;
        int  cyc;
        int  k;
        int  first_at;
        bit  got_done;
        bit  prev_stall;
        int  prev_data;
        int  prev_last;

        @(negedge clk);
        arm     = 1'b1;
        pretrig = v.pretrig[3:0];
        en      = 1'b0;
        trig    = 1'b0;
        @(negedge clk);
        arm = 1'b0;
        chk("busy_armed", busy, 1);

        d        = 0;
        last_wr  = -1;
        cyc      = 0;
        got_done = 1'b0;
        for (int g = 0; g < 400 && !got_done; g++) begin
            en   = ((cyc % v.period) == 0);
            din  = d[7:0];
            trig = en && ((d == v.trig_val) || (d == v.early_val));
            @(negedge clk);
            if (en) begin
                last_wr = d;
                d++;
            end
            cyc++;
            if (done) begin
                got_done = 1'b1;
                chk("done_after_sample", last_wr, v.done_val);
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);

        // Keep en/trig active during readout: they must not disturb the record.
        en         = 1'b1;
        din        = 8'hEE;
        trig       = 1'b1;
        arm        = v.arm_in_read;
        k          = 0;
        first_at   = -1;
        prev_stall = 1'b0;
        prev_data  = 0;
        prev_last  = 0;
        for (int g = 0; g < 600 && k < 16; g++) begin
            @(negedge clk);
            arm = 1'b0;
            if (g == 0) chk("done_one_cycle", done, 0);
            if (prev_stall) begin
                chk("hold_valid", rd_valid, 1);
                chk("hold_data", rd_data, prev_data);
                chk("hold_last", rd_last, prev_last);
            end
            if (rd_valid && first_at < 0) begin
                first_at = g + 1;
                chk("first_latency_ge2", int'(first_at >= 2), 1);
            end
            rd_ready = v.rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_valid && rd_ready) begin
                chk("beat_data", rd_data, (v.first + k) & 8'hFF);
                chk("beat_last", rd_last, int'(k == 15));
                k++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
        end
        if (k < 16) chk("readout_timeout", k, 16);
        @(negedge clk);
        chk("valid_after_last", rd_valid, 0);
        chk("busy_after_last", busy, 0);
        en       = 1'b0;
        trig     = 1'b0;
        rd_ready = 1'b1;
    endtask

    initial begin
        int d;

        vecs[0] = '{4,  10, -1, 1, 1'b0, 1'b0, 6,  21};
        vecs[1] = '{8,  12,  3, 1, 1'b0, 1'b0, 4,  19};
        vecs[2] = '{4,  10, -1, 1, 1'b1, 1'b0, 6,  21};
        vecs[3] = '{0,   7, -1, 1, 1'b0, 1'b0, 7,  22};
        vecs[4] = '{15, 20, -1, 1, 1'b0, 1'b0, 5,  20};
        vecs[5] = '{31, 20, -1, 1, 1'b0, 1'b0, 5,  20};
        vecs[6] = '{4,  40, -1, 3, 1'b0, 1'b1, 36, 51};

        rst      = 1'b1;
        en       = 1'b0;
        din      = '0;
        arm      = 1'b0;
        trig     = 1'b0;
        pretrig  = '0;
        rd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_capture(vecs[i]);
        end

        // Reset while collecting post-trigger samples.
        @(negedge clk);
        arm     = 1'b1;
        pretrig = 4'd4;
        @(negedge clk);
        arm = 1'b0;
        d   = 0;
        for (int g = 0; g < 16; g++) begin
            en   = 1'b1;
            din  = d[7:0];
            trig = (d == 10);
            @(negedge clk);
            d++;
        end
        chk("busy_in_post", busy, 1);
        rst  = 1'b1;
        en   = 1'b0;
        trig = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_done", done, 0);
        do_capture(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
